// File: rtl/h_step_calc.sv
// h_step_calc: step-size generator for the RK4 datapath.
//   Computes H = |C - X_o| / N using a restoring divider that produces one
//   quotient bit per cycle. H_half = H >> 1 and H_sign = (X_o > C). inexact
//   flags a nonzero remainder, and div_zero flags N == 0. A normal result is
//   ready W+1 edges after start is sampled; a divide by zero is ready 1 edge
//   after.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               request, sampled only in IDLE
//   C, X_o              end/start points, unsigned Q(W-FRAC).FRAC magnitudes
//   N                   integer step count
//   busy, done          in-flight flag, one-cycle completion pulse
//   H, H_half, H_sign   result magnitude, half magnitude, sign
//   inexact, div_zero   status of the last completed request
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SUB   | form |C - X_o| and its sign, load the divider or finish on N == 0
// DIV   | one restoring divide step per cycle, W steps in total
module h_step_calc #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] C,
  input  logic [W-1:0] X_o,
  input  logic [W-1:0] N,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] H,
  output logic [W-1:0] H_half,
  output logic         H_sign,
  output logic         inexact,
  output logic         div_zero
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  // A Q value divided by an integer stays in the same Q format, so FRAC only
  // constrains legal parameter sets and never shifts the quotient.
  if (FRAC >= W) begin : g_frac_check
    $error("h_step_calc: FRAC must be smaller than W");
  end

  typedef enum logic [1:0] {IDLE, SUB, DIV} state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       c_q, xo_q, n_q;
  logic [W-1:0]       quo;      // holds the dividend, shifted out as quotient bits shift in
  logic [W:0]         rem;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q;

  logic               x_gt_c;
  logic [W-1:0]       diff;
  logic [W+1:0]       rem_sh;
  logic               fits;
  logic [W:0]         rem_step;
  logic [W-1:0]       quo_step;
  logic               finish_dz, finish_div;

  always_comb begin
    x_gt_c   = (xo_q > c_q);
    diff     = x_gt_c ? (xo_q - c_q) : (c_q - xo_q);
    rem_sh   = {rem, quo[W-1]};
    fits     = (rem_sh >= {2'b00, n_q});
    rem_step = fits ? (rem_sh[W:0] - {1'b0, n_q}) : rem_sh[W:0];
    quo_step = {quo[W-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    finish_dz  = 1'b0;
    finish_div = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SUB;
      SUB: begin
        if (n_q == '0) begin
          finish_dz = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (cnt == '0) begin
          finish_div = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= '0;
      xo_q     <= '0;
      n_q      <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      done     <= 1'b0;
      H        <= '0;
      H_half   <= '0;
      H_sign   <= 1'b0;
      inexact  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= finish_dz | finish_div;
      case (state)
        IDLE: begin
          if (start) begin
            c_q  <= C;
            xo_q <= X_o;
            n_q  <= N;
          end
        end
        SUB: begin
          quo    <= diff;
          rem    <= '0;
          cnt    <= CNT_W'(W - 1);
          sign_q <= x_gt_c;
        end
        DIV: begin
          quo <= quo_step;
          rem <= rem_step;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
      if (finish_dz) begin
        H        <= '1;
        H_half   <= {1'b0, {(W-1){1'b1}}};
        H_sign   <= x_gt_c;
        inexact  <= 1'b0;
        div_zero <= 1'b1;
      end
      if (finish_div) begin
        H        <= quo_step;
        H_half   <= quo_step >> 1;
        H_sign   <= sign_q;
        inexact  <= (rem_step != '0);
        div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_h_step_calc.sv
module tb_h_step_calc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] C = '0, X_o = '0, N = '0;
  logic        busy, done, H_sign, inexact, div_zero;
  logic [31:0] H, H_half;

  int total = 0;
  int bad = 0;

  h_step_calc #(.W(32), .FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .C(C), .X_o(X_o), .N(N),
    .busy(busy), .done(done), .H(H), .H_half(H_half), .H_sign(H_sign),
    .inexact(inexact), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current negedge; the next posedge samples it.
  task automatic launch(input logic [31:0] c, input logic [31:0] x, input logic [31:0] n);
    C = c; X_o = x; N = n; start = 1'b1;
  endtask

  // Passes the sampling edge, scrambles inputs, then counts edges until done.
  // inj_at >= 1 re-asserts start (with other operands) so it is sampled at edge k+inj_at+1.
  task automatic wait_res(input int inj_at, output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b0;
    C = $urandom; X_o = $urandom; N = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done) begin
        chk("busy_in_done", {63'd0, busy}, 64'd0);
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (lat == inj_at) begin
        C = 32'h00FF0000; X_o = 32'h0; N = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  // Reference: plain arithmetic on the request's operands.
  task automatic check_res(input string tag, input logic [31:0] c, input logic [31:0] x,
                           input logic [31:0] n, input int lat);
    longint unsigned d, q, r;
    logic [31:0] eh, ehh;
    bit es, ei, ez;
    int elat;
    d  = (c >= x) ? longint'(c) - longint'(x) : longint'(x) - longint'(c);
    es = (x > c);
    if (n == 0) begin
      eh = 32'hFFFFFFFF; ehh = 32'h7FFFFFFF; ei = 0; ez = 1; elat = 1;
    end else begin
      q = d / longint'(n);
      r = d % longint'(n);
      eh = q[31:0]; ehh = eh / 2; ei = (r != 0); ez = 0; elat = 33;
    end
    chk({tag, ".lat"},     64'(lat),      64'(elat));
    chk({tag, ".H"},       {32'd0, H},      {32'd0, eh});
    chk({tag, ".H_half"},  {32'd0, H_half}, {32'd0, ehh});
    chk({tag, ".H_sign"},  {63'd0, H_sign},   {63'd0, es});
    chk({tag, ".inexact"}, {63'd0, inexact},  {63'd0, ei});
    chk({tag, ".div_zero"},{63'd0, div_zero}, {63'd0, ez});
  endtask

  task automatic check_pulse_end(input string tag, input logic [31:0] h_exp);
    @(negedge clk);
    chk({tag, ".done_low"}, {63'd0, done}, 64'd0);
    chk({tag, ".H_hold"},   {32'd0, H},    {32'd0, h_exp});
  endtask

  initial begin
    int lat;
    bit bok;
    int dcount;
    logic [31:0] rc, rx, rn;

    repeat (3) @(negedge clk);
    chk("rst.busy",     {63'd0, busy},     64'd0);
    chk("rst.done",     {63'd0, done},     64'd0);
    chk("rst.H",        {32'd0, H},        64'd0);
    chk("rst.H_half",   {32'd0, H_half},   64'd0);
    chk("rst.flags",    {61'd0, H_sign, inexact, div_zero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: exact
    launch(32'h000A0000, 32'h0, 32'd4);
    wait_res(-1, lat, bok);
    check_res("exact", 32'h000A0000, 32'h0, 32'd4, lat);
    chk("exact.H_const", {32'd0, H}, 64'h00028000);
    chk("exact.busy_ok", {63'd0, bok}, 64'd1);
    check_pulse_end("exact", 32'h00028000);

    // 2: negative, inexact
    launch(32'h0, 32'h00010000, 32'd3);
    wait_res(-1, lat, bok);
    check_res("neg", 32'h0, 32'h00010000, 32'd3, lat);
    chk("neg.H_half_const", {32'd0, H_half}, 64'h00002AAA);
    check_pulse_end("neg", 32'h00005555);

    // 3: divide by zero
    launch(32'h00050000, 32'h00010000, 32'd0);
    wait_res(-1, lat, bok);
    check_res("dz", 32'h00050000, 32'h00010000, 32'd0, lat);
    check_pulse_end("dz", 32'hFFFFFFFF);

    // 4: equal end points
    launch(32'h00030000, 32'h00030000, 32'd7);
    wait_res(-1, lat, bok);
    check_res("eq", 32'h00030000, 32'h00030000, 32'd7, lat);
    check_pulse_end("eq", 32'h0);

    // 5: start while busy is ignored; start in done cycle chains
    launch(32'h000A0000, 32'h0, 32'd4);
    wait_res(4, lat, bok);
    check_res("ign", 32'h000A0000, 32'h0, 32'd4, lat);
    launch(32'h0, 32'h00010000, 32'd3);
    wait_res(-1, lat, bok);
    check_res("chain", 32'h0, 32'h00010000, 32'd3, lat);
    chk("chain.busy_ok", {63'd0, bok}, 64'd1);
    check_pulse_end("chain", 32'h00005555);

    // 6: reset mid-operation
    launch(32'h00070000, 32'h00010000, 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.busy",   {63'd0, busy},   64'd0);
    chk("mrst.done",   {63'd0, done},   64'd0);
    chk("mrst.H",      {32'd0, H},      64'd0);
    chk("mrst.H_half", {32'd0, H_half}, 64'd0);
    chk("mrst.flags",  {61'd0, H_sign, inexact, div_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("mrst.no_done", 64'(dcount), 64'd0);
    launch(32'h00070000, 32'h00010000, 32'd5);
    wait_res(-1, lat, bok);
    check_res("post_rst", 32'h00070000, 32'h00010000, 32'd5, lat);
    check_pulse_end("post_rst", 32'h00013333);

    // Randomized requests
    for (int i = 0; i < 24; i++) begin
      rc = $urandom;
      rx = ($urandom_range(0, 7) == 0) ? rc : $urandom;
      case ($urandom_range(0, 3))
        0: rn = 32'd0;
        1: rn = $urandom_range(1, 15);
        2: rn = $urandom;
        default: rn = 32'd1;
      endcase
      launch(rc, rx, rn);
      wait_res(-1, lat, bok);
      check_res("rand", rc, rx, rn, lat);
      @(negedge clk);
      chk("rand.done_low", {63'd0, done}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
